branch_redirect_flush_ctrl: RTL and testbench
=============================================

BRANCH_REDIRECT_FLUSH_CTRL -- requirements
Module: branch_redirect_flush_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of consecutive cycles flush outputs stay asserted per taken branch (legal range 1..7).
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 and_control  input  1  registered branch-taken signal (branch AND zero) from the ID/EX control register.
REQ-005 ex_valid  input  1  EX stage holds a valid, non-bubble instruction.
REQ-006 hold  input  1  global pipeline stall; freezes this block.
REQ-007 branch_target  input  32  branch target address computed in EX.
REQ-008 pc_src  output  1  selects pc_target as next PC (registered).
REQ-009 pc_target  output  32  latched redirect address (registered).
REQ-010 flush_if_id  output  1  bubble IF/ID register (registered).
REQ-011 flush_id_ex  output  1  bubble ID/EX register (registered).
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 redirect_count  output  16  number of accepted taken branches since reset.

Function
REQ-014 FSM states SHALL be IDLE, REDIRECT and FLUSH; all outputs except pc_target and redirect_count are Moore decodes of state.
REQ-015 In IDLE, when hold=0 and and_control=1 and ex_valid=1 at posedge: next state REDIRECT, branch_target captured into pc_target, redirect_count incremented.
REQ-016 In IDLE, when the condition in REQ-015 is false, state, pc_target and redirect_count SHALL remain unchanged.
REQ-017 REDIRECT SHALL last exactly one cycle: pc_src=1, flush_if_id=1, flush_id_ex=1, busy=1.
REQ-018 On leaving REDIRECT: next state IDLE if FLUSH_CYCLES=1, else FLUSH with an internal 3-bit counter loaded to FLUSH_CYCLES-2.
REQ-019 In FLUSH: pc_src=0, flush_if_id=1, flush_id_ex=1, busy=1; counter decrements each non-hold cycle; transition to IDLE when counter is 0 at posedge.
REQ-020 Total flush assertion per accepted branch SHALL be exactly FLUSH_CYCLES non-hold cycles, beginning one cycle after the accepting edge.
REQ-021 In REDIRECT and FLUSH, and_control and ex_valid SHALL be ignored; branches in flushed slots are never accepted.
REQ-022 A new branch SHALL be accepted no earlier than the first posedge at which state is IDLE (minimum spacing FLUSH_CYCLES+1 cycles between accepting edges).
REQ-023 While hold=1, state, internal counter, pc_target and redirect_count SHALL hold, and outputs SHALL keep their current values.
REQ-024 redirect_count SHALL saturate at 16'hFFFF and never wrap.
REQ-025 In IDLE: pc_src=0, flush_if_id=0, flush_id_ex=0, busy=0; pc_target keeps the last captured address.

Reset
REQ-026 reset=1 at a posedge SHALL force state IDLE, internal counter 0, pc_target=32'h0, redirect_count=16'h0, pc_src=flush_if_id=flush_id_ex=busy=0.
REQ-027 reset SHALL take priority over hold and over any branch acceptance, including reset asserted mid-REDIRECT or mid-FLUSH.
REQ-028 The first posedge after reset deasserts SHALL be able to accept a branch.

Verification
REQ-029 FLUSH_CYCLES=2; reset then and_control=1, ex_valid=1, branch_target=32'h0040_0020 for one cycle -> next cycle pc_src=1, pc_target=32'h0040_0020, both flushes=1; following cycle pc_src=0, flushes=1; then all 0, redirect_count=1.
REQ-030 and_control=1 with ex_valid=0, and ex_valid=1 with and_control=0 -> no state change, pc_src and flushes stay 0, redirect_count unchanged.
REQ-031 and_control held 1 continuously for 10 cycles, FLUSH_CYCLES=2 -> acceptances at edges 0, 3, 6, 9; redirect_count=4; pc_src pulses one cycle each.
REQ-032 hold=1 for 3 cycles during FLUSH -> flushes remain 1 for those 3 cycles, then exactly the remaining flush cycle(s) before IDLE; branch_target changes during hold do not alter pc_target.
REQ-033 reset=1 during REDIRECT -> next cycle all outputs 0, pc_target=32'h0, redirect_count=0; FLUSH_CYCLES=1 build: single-cycle pc_src/flush pulse then IDLE.
REQ-034 Preload redirect_count to 16'hFFFE via 2 accepted branches on a forced-value build or 65534 branches -> two further acceptances leave redirect_count=16'hFFFF.

Source files
------------

// File: rtl/branch_redirect_flush_ctrl.sv
// Branch redirect / pipeline flush controller: captures a taken-branch target,
// redirects the PC for one cycle and bubbles IF/ID and ID/EX for FLUSH_CYCLES cycles.
module branch_redirect_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES      = 2,
  parameter logic [15:0] COUNT_RESET_VALUE = 16'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        and_control,
  input  logic        ex_valid,
  input  logic        hold,
  input  logic [31:0] branch_target,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        busy,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  // REDIRECT already provides the first flush cycle; FLUSH covers the rest.
  localparam logic [2:0] CNT_LOAD = (FLUSH_CYCLES >= 2) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_t     state;
  logic [2:0] flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      pc_target      <= '0;
      redirect_count <= COUNT_RESET_VALUE;
      pc_src         <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      busy           <= 1'b0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (and_control && ex_valid) begin
            state       <= REDIRECT;
            pc_target   <= branch_target;
            if (redirect_count != '1) begin
              redirect_count <= redirect_count + 16'd1;
            end
            pc_src      <= 1'b1;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
            busy        <= 1'b1;
          end
        end
        REDIRECT: begin
          pc_src <= 1'b0;
          if (FLUSH_CYCLES <= 1) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
            busy        <= 1'b0;
          end else begin
            state     <= FLUSH;
            flush_cnt <= CNT_LOAD;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
            busy        <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state       <= IDLE;
          flush_cnt   <= '0;
          pc_src      <= 1'b0;
          flush_if_id <= 1'b0;
          flush_id_ex <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_flush_ctrl.sv
// Self-checking bench: three builds (FLUSH_CYCLES 2, 1 with near-saturated count, 7)
// share one stimulus stream and are compared every cycle against a countdown model.
module tb_branch_redirect_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset, hold, and_control, ex_valid;
  logic [31:0] branch_target;

  logic [2:0]  ps, fi, fe, bz;
  logic [31:0] pt [3];
  logic [15:0] rc [3];

  int checks = 0;
  int errors = 0;

  int          fcs  [3];
  logic [15:0] pre  [3];
  int          left [3];
  logic [31:0] mtgt [3];
  logic [15:0] mcnt [3];

  always #5 clk = ~clk;

  branch_redirect_flush_ctrl #(.FLUSH_CYCLES(2), .COUNT_RESET_VALUE(16'h0000)) dut_fc2 (
    .clock(clk), .reset(reset), .and_control(and_control), .ex_valid(ex_valid),
    .hold(hold), .branch_target(branch_target), .pc_src(ps[0]), .pc_target(pt[0]),
    .flush_if_id(fi[0]), .flush_id_ex(fe[0]), .busy(bz[0]), .redirect_count(rc[0]));

  branch_redirect_flush_ctrl #(.FLUSH_CYCLES(1), .COUNT_RESET_VALUE(16'hFFFE)) dut_fc1 (
    .clock(clk), .reset(reset), .and_control(and_control), .ex_valid(ex_valid),
    .hold(hold), .branch_target(branch_target), .pc_src(ps[1]), .pc_target(pt[1]),
    .flush_if_id(fi[1]), .flush_id_ex(fe[1]), .busy(bz[1]), .redirect_count(rc[1]));

  branch_redirect_flush_ctrl #(.FLUSH_CYCLES(7), .COUNT_RESET_VALUE(16'h0000)) dut_fc7 (
    .clock(clk), .reset(reset), .and_control(and_control), .ex_valid(ex_valid),
    .hold(hold), .branch_target(branch_target), .pc_src(ps[2]), .pc_target(pt[2]),
    .flush_if_id(fi[2]), .flush_id_ex(fe[2]), .busy(bz[2]), .redirect_count(rc[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // left = flush cycles still to be shown; a branch is taken only when nothing is left.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        left[i] = 0;
        mtgt[i] = '0;
        mcnt[i] = pre[i];
      end else if (!hold) begin
        if (left[i] == 0) begin
          if (and_control && ex_valid) begin
            left[i] = fcs[i];
            mtgt[i] = branch_target;
            if (mcnt[i] != 16'hFFFF) mcnt[i] = mcnt[i] + 16'd1;
          end
        end else begin
          left[i] = left[i] - 1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pc_src[%0d]", i),         32'(ps[i]), 32'(left[i] == fcs[i]));
      chk($sformatf("flush_if_id[%0d]", i),    32'(fi[i]), 32'(left[i] > 0));
      chk($sformatf("flush_id_ex[%0d]", i),    32'(fe[i]), 32'(left[i] > 0));
      chk($sformatf("busy[%0d]", i),           32'(bz[i]), 32'(left[i] > 0));
      chk($sformatf("pc_target[%0d]", i),      pt[i], mtgt[i]);
      chk($sformatf("redirect_count[%0d]", i), 32'(rc[i]), 32'(mcnt[i]));
    end
  endtask

  task automatic step(input logic r, input logic h, input logic ac, input logic ev,
                      input logic [31:0] bt);
    reset = r; hold = h; and_control = ac; ex_valid = ev; branch_target = bt;
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  int pulses;

  initial begin
    fcs[0] = 2; fcs[1] = 1; fcs[2] = 7;
    pre[0] = 16'h0000; pre[1] = 16'hFFFE; pre[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      left[i] = 0; mtgt[i] = '0; mcnt[i] = '0;
    end
    reset = 1'b1; hold = 1'b0; and_control = 1'b0; ex_valid = 1'b0; branch_target = '0;

    // Reset state
    step(1, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 32'hDEAD_BEEF);
    chk("reset_pc_target", pt[0], 32'h0);
    chk("reset_count", 32'(rc[0]), 32'h0);
    chk("reset_busy", 32'(bz[0]), 32'h0);

    // Single taken branch, first edge after reset
    step(0, 0, 1, 1, 32'h0040_0020);
    chk("lit_redirect_pc_src", 32'(ps[0]), 32'h1);
    chk("lit_redirect_target", pt[0], 32'h0040_0020);
    chk("lit_redirect_flush", 32'({fi[0], fe[0]}), 32'h3);
    step(0, 0, 0, 0, 32'h0);
    chk("lit_flush_pc_src", 32'(ps[0]), 32'h0);
    chk("lit_flush_flush", 32'({fi[0], fe[0]}), 32'h3);
    step(0, 0, 0, 0, 32'h0);
    chk("lit_idle_flush", 32'({fi[0], fe[0], ps[0]}), 32'h0);
    chk("lit_idle_count", 32'(rc[0]), 32'h1);
    chk("lit_fc1_saturated", 32'(rc[1]), 32'hFFFF);

    // Half-qualified branches are ignored
    step(0, 0, 1, 0, 32'h1111_1111);
    step(0, 0, 0, 1, 32'h2222_2222);
    chk("lit_unqualified_count", 32'(rc[0]), 32'h1);
    chk("lit_unqualified_target", pt[0], 32'h0040_0020);

    // Continuous and_control: accepts spaced FLUSH_CYCLES+1 apart
    step(1, 0, 0, 0, 32'h0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 1, 32'h1000 + 32'(k));
      if (ps[0]) pulses++;
    end
    chk("lit_stream_count_fc2", 32'(rc[0]), 32'd4);
    chk("lit_stream_pulses_fc2", 32'(pulses), 32'd4);
    chk("lit_stream_target_fc2", pt[0], 32'h1009);
    chk("lit_stream_count_fc7", 32'(rc[2]), 32'd2);
    chk("lit_stream_count_fc1", 32'(rc[1]), 32'hFFFF);

    // Hold during FLUSH
    step(1, 0, 0, 0, 32'h0);
    step(0, 0, 1, 1, 32'hA000_0000);
    step(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 1, 32'hB000_0000 + 32'(k));
      chk("lit_hold_flush", 32'({fi[0], fe[0]}), 32'h3);
      chk("lit_hold_target", pt[0], 32'hA000_0000);
    end
    step(0, 0, 0, 0, 32'h0);
    chk("lit_after_hold_idle", 32'(fi[0]), 32'h0);

    // Reset in the middle of REDIRECT
    step(0, 0, 1, 1, 32'hC000_0004);
    chk("lit_pre_reset_pc_src", 32'(ps[0]), 32'h1);
    step(1, 1, 1, 1, 32'hC000_0008);
    chk("lit_mid_reset_target", pt[0], 32'h0);
    chk("lit_mid_reset_count", 32'(rc[0]), 32'h0);
    chk("lit_mid_reset_outs", 32'({ps[0], fi[0], fe[0], bz[0]}), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
